wb_intercon_1x2: RTL and testbench

WB_INTERCON_1X2 -- requirements
Module: wb_intercon_1x2

---
 rtl/wb_intercon_1x2.sv | 154 +++++++++++++++
 tb/tb_wb_intercon_1x2.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon_1x2.sv
// wb_intercon_1x2 -- single-master, two-slave Wishbone interconnect.
//
// Decodes the master address in IDLE, grants one slave (slave 0 wins on overlap) and
// forwards the cycle. While ACTIVE, the granted slave's ack/err/data are returned to the
// master combinationally. The interconnect terminates with a one-cycle bus error when
// the address hits no slave, or when the granted slave stalls for TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_cyc_i, m_stb_i, m_we_i     master cycle, strobe, write-enable
//   m_adr_i, m_dat_i, m_sel_i    master address, write data, byte selects
//   m_dat_o, m_ack_o, m_err_o    read data and termination to master
//   s_adr_o, s_dat_o, s_we_o,
//   s_sel_o                      shared slave bus (pass-through of master signals)
//   s0_cyc_o, s0_stb_o,
//   s1_cyc_o, s1_stb_o           per-slave cycle and strobe
//   s0_dat_i, s1_dat_i           slave read data
//   s0_ack_i, s0_err_i,
//   s1_ack_i, s1_err_i           slave terminations
module wb_intercon_1x2 #(
   parameter logic [31:0] SLV0_PREFIX = 32'h0000_0000,
   parameter logic [31:0] SLV0_MASK   = 32'hFFFF_0000,
   parameter logic [31:0] SLV1_PREFIX = 32'h1100_0000,
   parameter logic [31:0] SLV1_MASK   = 32'hFF00_0000,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m_cyc_i,
   input  logic        m_stb_i,
   input  logic        m_we_i,
   input  logic [31:0] m_adr_i,
   input  logic [31:0] m_dat_i,
   input  logic [3:0]  m_sel_i,
   output logic [31:0] m_dat_o,
   output logic        m_ack_o,
   output logic        m_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s0_cyc_o,
   output logic        s0_stb_o,
   output logic        s1_cyc_o,
   output logic        s1_stb_o,
   input  logic [31:0] s0_dat_i,
   input  logic [31:0] s1_dat_i,
   input  logic        s0_ack_i,
   input  logic        s0_err_i,
   input  logic        s1_ack_i,
   input  logic        s1_err_i
);

   typedef enum logic [1:0] {StIdle, StActive, StErr} state_e;

   // Last counter value before the stall is declared a timeout.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        sel_q, sel_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        match0, match1;
   logic        slv_ack, slv_err;
   logic [31:0] slv_dat;

   assign match0 = (m_adr_i & SLV0_MASK) == SLV0_PREFIX;
   assign match1 = (m_adr_i & SLV1_MASK) == SLV1_PREFIX;

   // Termination and data from the granted slave.
   assign slv_ack = sel_q ? s1_ack_i : s0_ack_i;
   assign slv_err = sel_q ? s1_err_i : s0_err_i;
   assign slv_dat = sel_q ? s1_dat_i : s0_dat_i;

   // Shared slave bus is a plain pass-through in every state.
   assign s_adr_o = m_adr_i;
   assign s_dat_o = m_dat_i;
   assign s_we_o  = m_we_i;
   assign s_sel_o = m_sel_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         sel_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      s0_cyc_o = 1'b0;
      s0_stb_o = 1'b0;
      s1_cyc_o = 1'b0;
      s1_stb_o = 1'b0;
      m_ack_o  = 1'b0;
      m_err_o  = 1'b0;
      m_dat_o  = 32'h0;

      case (state_q)
         StIdle: begin
            if (m_cyc_i && m_stb_i) begin
               cnt_d = 8'd0;
               if (match0) begin
                  state_d = StActive;
                  sel_d   = 1'b0;
               end else if (match1) begin
                  state_d = StActive;
                  sel_d   = 1'b1;
               end else begin
                  state_d = StErr;
               end
            end
         end

         StActive: begin
            s0_cyc_o = ~sel_q & m_cyc_i;
            s0_stb_o = ~sel_q & m_stb_i;
            s1_cyc_o =  sel_q & m_cyc_i;
            s1_stb_o =  sel_q & m_stb_i;
            // A slave raising both ack and err is reported as an error only.
            m_err_o  = slv_err;
            m_ack_o  = slv_ack & ~slv_err;
            m_dat_o  = slv_dat;

            // Slave termination has priority over abort and timeout.
            if (slv_ack || slv_err) begin
               state_d = StIdle;
            end else if (!m_cyc_i) begin
               state_d = StIdle;
            end else if (cnt_q == TimeoutLast) begin
               state_d = StErr;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         StErr: begin
            m_err_o = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_intercon_1x2.sv
// Directed self-checking bench for wb_intercon_1x2. Inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later, well away from the next edge.
module tb_wb_intercon_1x2;

   logic        clk;
   logic        rst;
   logic        m_cyc, m_stb, m_we;
   logic [31:0] m_adr, m_dat;
   logic [3:0]  m_sel;
   logic [31:0] m_dat_o;
   logic        m_ack_o, m_err_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic        s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o;
   logic [31:0] s0_dat, s1_dat;
   logic        s0_ack, s0_err, s1_ack, s1_err;

   // Second instance with slave 1 matching every address, for the overlap case.
   logic [31:0] d2_m_dat_o, d2_s_adr_o, d2_s_dat_o;
   logic        d2_m_ack_o, d2_m_err_o, d2_s_we_o;
   logic [3:0]  d2_s_sel_o;
   logic        d2_s0_cyc_o, d2_s0_stb_o, d2_s1_cyc_o, d2_s1_stb_o;

   logic [5:0]  obs, obs2;
   int          n_checks = 0;
   int          n_fail   = 0;

   assign obs  = {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o, m_ack_o, m_err_o};
   assign obs2 = {d2_s0_cyc_o, d2_s0_stb_o, d2_s1_cyc_o, d2_s1_stb_o, d2_m_ack_o, d2_m_err_o};

   wb_intercon_1x2 dut (
      .clk_i(clk), .rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o),
      .s0_dat_i(s0_dat), .s1_dat_i(s1_dat),
      .s0_ack_i(s0_ack), .s0_err_i(s0_err), .s1_ack_i(s1_ack), .s1_err_i(s1_err)
   );

   wb_intercon_1x2 #(
      .SLV1_PREFIX(32'h0000_0000),
      .SLV1_MASK  (32'h0000_0000)
   ) dut_ovl (
      .clk_i(clk), .rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_dat_o(d2_m_dat_o), .m_ack_o(d2_m_ack_o), .m_err_o(d2_m_err_o),
      .s_adr_o(d2_s_adr_o), .s_dat_o(d2_s_dat_o), .s_we_o(d2_s_we_o), .s_sel_o(d2_s_sel_o),
      .s0_cyc_o(d2_s0_cyc_o), .s0_stb_o(d2_s0_stb_o),
      .s1_cyc_o(d2_s1_cyc_o), .s1_stb_o(d2_s1_stb_o),
      .s0_dat_i(s0_dat), .s1_dat_i(s1_dat),
      .s0_ack_i(s0_ack), .s0_err_i(s0_err), .s1_ack_i(s1_ack), .s1_err_i(s1_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      m_cyc  = 1'b0;
      m_stb  = 1'b0;
      m_we   = 1'b0;
      s0_ack = 1'b0;
      s0_err = 1'b0;
      s1_ack = 1'b0;
      s1_err = 1'b0;
   endtask

   task automatic start(input logic [31:0] adr, input logic we, input logic [31:0] dat);
      m_adr = adr;
      m_dat = dat;
      m_we  = we;
      m_sel = 4'hF;
      m_cyc = 1'b1;
      m_stb = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start(32'h0000_0040, 1'b1, 32'hA5A5_0001);
      m_sel  = 4'h5;
      s0_dat = 32'hFFFF_FFFF;
      next_cycle();
      next_cycle();
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL reset_strobes: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      n_checks++;
      if (m_dat_o !== 32'h0) begin
         $display("FAIL reset_dat: got %h expected %h", m_dat_o, 32'h0);
         n_fail++;
      end
      n_checks++;
      if ({s_adr_o, s_dat_o, s_we_o, s_sel_o} !== {32'h0000_0040, 32'hA5A5_0001, 1'b1, 4'h5}) begin
         $display("FAIL reset_passthru: got %h %h %b %h", s_adr_o, s_dat_o, s_we_o, s_sel_o);
         n_fail++;
      end
      idle_bus();
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_write_s0();
      start(32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL wr_decode: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      n_checks++;
      if ({s_adr_o, s_dat_o, s_we_o} !== {32'h0000_0040, 32'hDEAD_BEEF, 1'b1}) begin
         $display("FAIL wr_passthru: got %h %h %b", s_adr_o, s_dat_o, s_we_o);
         n_fail++;
      end
      next_cycle();
      s0_ack = 1'b1;
      #1;
      n_checks++;
      if (obs !== 6'b110010) begin
         $display("FAIL wr_ack: got %b expected %b", obs, 6'b110010);
         n_fail++;
      end
      next_cycle();
      idle_bus();
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL wr_idle: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
   endtask

   task automatic test_read_s1_wait();
      s0_dat = 32'hBAD0_0000;
      s1_dat = 32'hFFFF_FFFF;
      start(32'h1100_0008, 1'b0, 32'h0);
      next_cycle();
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_checks++;
         if (obs !== 6'b001100 || m_dat_o !== 32'hFFFF_FFFF) begin
            $display("FAIL rd_wait%0d: got %b/%h expected %b/%h", k, obs, m_dat_o,
                     6'b001100, 32'hFFFF_FFFF);
            n_fail++;
         end
         next_cycle();
      end
      s1_ack = 1'b1;
      s1_dat = 32'h1234_5678;
      #1;
      n_checks++;
      if (obs !== 6'b001110 || m_dat_o !== 32'h1234_5678) begin
         $display("FAIL rd_ack: got %b/%h expected %b/%h", obs, m_dat_o, 6'b001110,
                  32'h1234_5678);
         n_fail++;
      end
      next_cycle();
      idle_bus();
      #1;
      n_checks++;
      if (obs !== 6'b000000 || m_dat_o !== 32'h0) begin
         $display("FAIL rd_idle: got %b/%h expected %b/%h", obs, m_dat_o, 6'b000000, 32'h0);
         n_fail++;
      end
      next_cycle();
   endtask

   task automatic test_decode_err();
      start(32'h2000_0000, 1'b0, 32'h0);
      next_cycle();
      idle_bus();
      #1;
      n_checks++;
      if (obs !== 6'b000001) begin
         $display("FAIL dec_err: got %b expected %b", obs, 6'b000001);
         n_fail++;
      end
      next_cycle();
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL dec_err_once: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
   endtask

   task automatic test_timeout(input bit inject_ack);
      logic [5:0] exp;
      start(32'h0000_0100, 1'b0, 32'h0);
      next_cycle();
      for (int k = 1; k <= 16; k++) begin
         if (inject_ack && k == 16) s0_ack = 1'b1;
         exp = (inject_ack && k == 16) ? 6'b110010 : 6'b110000;
         #1;
         n_checks++;
         if (obs !== exp) begin
            $display("FAIL to_active%0d(ack=%0d): got %b expected %b", k, inject_ack, obs, exp);
            n_fail++;
         end
         next_cycle();
      end
      // Master keeps asserting here, the interconnect must still gate the slave off.
      exp = inject_ack ? 6'b000000 : 6'b000001;
      if (inject_ack) idle_bus();
      #1;
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL to_end(ack=%0d): got %b expected %b", inject_ack, obs, exp);
         n_fail++;
      end
      idle_bus();
      next_cycle();
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL to_idle(ack=%0d): got %b expected %b", inject_ack, obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
   endtask

   task automatic test_abort();
      start(32'h0000_0040, 1'b0, 32'h0);
      next_cycle();
      for (int k = 1; k <= 2; k++) begin
         #1;
         n_checks++;
         if (obs !== 6'b110000) begin
            $display("FAIL abort_active%0d: got %b expected %b", k, obs, 6'b110000);
            n_fail++;
         end
         next_cycle();
      end
      idle_bus();
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL abort_drop: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
      // New request to slave 1 must see a fresh decode cycle first.
      start(32'h1100_0000, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL abort_redecode: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
      s1_ack = 1'b1;
      #1;
      n_checks++;
      if (obs !== 6'b001110) begin
         $display("FAIL abort_next_ack: got %b expected %b", obs, 6'b001110);
         n_fail++;
      end
      next_cycle();
      idle_bus();
      next_cycle();
   endtask

   task automatic test_reset_mid();
      start(32'h0000_0040, 1'b0, 32'h0);
      next_cycle();
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== 6'b110000) begin
         $display("FAIL rst_mid_before: got %b expected %b", obs, 6'b110000);
         n_fail++;
      end
      next_cycle();
      rst = 1'b0;
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL rst_mid_after: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      idle_bus();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      start(32'h0000_0040, 1'b1, 32'h0000_0001);
      next_cycle();
      s0_ack = 1'b1;
      #1;
      n_checks++;
      if (obs !== 6'b110010) begin
         $display("FAIL b2b_first_ack: got %b expected %b", obs, 6'b110010);
         n_fail++;
      end
      next_cycle();
      s0_ack = 1'b0;
      start(32'h1100_0004, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL b2b_decode: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
      s1_ack = 1'b1;
      s1_err = 1'b1;
      #1;
      n_checks++;
      if (obs !== 6'b001101) begin
         $display("FAIL b2b_ack_err: got %b expected %b", obs, 6'b001101);
         n_fail++;
      end
      next_cycle();
      idle_bus();
      #1;
      n_checks++;
      if (obs !== 6'b000000) begin
         $display("FAIL b2b_idle: got %b expected %b", obs, 6'b000000);
         n_fail++;
      end
      next_cycle();
   endtask

   task automatic test_overlap();
      start(32'h0000_0010, 1'b0, 32'h0);
      next_cycle();
      s0_ack = 1'b1;
      #1;
      n_checks++;
      if (obs2 !== 6'b110010) begin
         $display("FAIL overlap_sel: got %b expected %b", obs2, 6'b110010);
         n_fail++;
      end
      next_cycle();
      idle_bus();
      next_cycle();
      // Unmapped on the default instance, slave 1 on the catch-all instance.
      start(32'h2000_0000, 1'b0, 32'h0);
      next_cycle();
      s1_ack = 1'b1;
      #1;
      n_checks++;
      if (obs2 !== 6'b001110) begin
         $display("FAIL overlap_catchall: got %b expected %b", obs2, 6'b001110);
         n_fail++;
      end
      next_cycle();
      idle_bus();
      next_cycle();
   endtask

   initial begin
      rst    = 1'b1;
      m_adr  = 32'h0;
      m_dat  = 32'h0;
      m_sel  = 4'h0;
      s0_dat = 32'h0;
      s1_dat = 32'h0;
      idle_bus();
      test_reset();
      test_write_s0();
      test_read_s1_wait();
      test_decode_err();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_overlap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
